// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_ctrl  (with helper full_adder_nbits)
//  Description : Sequential shift-and-add unsigned multiplier. A single
//                width-bit ripple adder is reused for `width` iterations,
//                one partial-product add per clock, under a start/busy/done
//                handshake.
//  Ports       : clk_i    - clock, rising edge
//                rst_n_i  - asynchronous active-low reset
//                start_i  - multiply request, sampled only when idle
//                a_i      - multiplicand (width bits), captured on accept
//                b_i      - multiplier   (width bits), captured on accept
//                busy_o   - operation in progress (RUN or DONE)
//                done_o   - one-cycle pulse when p_o holds a new product
//                p_o      - last completed product (2*width bits)
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  full_adder_nbits : width-bit ripple-carry adder, carry-out kept as MSB.
// ----------------------------------------------------------------------------
module full_adder_nbits #(
   parameter int width = 8
) (
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   output logic [width:0]   s_o
);

   logic [width:0] w_carry;

   assign w_carry[0] = 1'b0;

   generate
      for (genvar i = 0; i < width; i++) begin : g_bit
         assign s_o[i]       = a_i[i] ^ b_i[i] ^ w_carry[i];
         assign w_carry[i+1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
      end
   endgenerate

   assign s_o[width] = w_carry[width];

endmodule

// ----------------------------------------------------------------------------
//  mult_seq_ctrl : controller + datapath for the shift-and-add multiply.
// ----------------------------------------------------------------------------
module mult_seq_ctrl #(
   parameter int width = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic [width-1:0]   a_i,
   input  logic [width-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*width-1:0] p_o
);

   localparam int             C_CNT_W    = $clog2(width + 1);
   localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(width - 1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [width-1:0]     r_mcand;
   logic [2*width-1:0]   r_prod;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [2*width-1:0]   r_p;

   logic [width-1:0]     w_addend;
   logic [width:0]       w_sum;
   logic [2*width-1:0]   w_prod_nxt;
   logic                 w_accept;
   logic                 w_last;

   // Partial product: add the multiplicand only when the current multiplier
   // bit (always sitting in prod[0]) is set.
   assign w_addend = r_prod[0] ? r_mcand : '0;

   full_adder_nbits #(
      .width (width)
   ) u_adder (
      .a_i (r_prod[2*width-1:width]),
      .b_i (w_addend),
      .s_o (w_sum)
   );

   // Sum (with carry) becomes the new high half; the multiplier half shifts
   // right by one, dropping the bit just consumed.
   assign w_prod_nxt = {w_sum, r_prod[width-1:1]};

   assign w_accept = (r_state == ST_IDLE) && start_i;
   assign w_last   = (r_state == ST_RUN) && (r_cnt == C_LAST_CNT);

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM next-state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start_i) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_mcand <= '0;
         r_prod  <= '0;
         r_cnt   <= '0;
         r_p     <= '0;
      end else if (w_accept) begin
         r_mcand <= a_i;
         r_prod  <= {{width{1'b0}}, b_i};
         r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         r_prod <= w_prod_nxt;
         r_cnt  <= r_cnt + C_CNT_ONE;
         if (w_last) begin
            r_p <= w_prod_nxt;
         end
      end
   end

   assign busy_o = (r_state != ST_IDLE);
   assign done_o = (r_state == ST_DONE);
   assign p_o    = r_p;

endmodule
`default_nettype wire

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential shift-and-add multiplier controller for the calculator datapath. It computes an unsigned `width`×`width` product by time-sharing a single `full_adder_nbits` instance over `width` iterations, one partial-product add per clock. It sits between the calculator's operation decoder and result register. It provides a start/busy/done handshake, so the multiply operation needs no combinational array multiplier.

## Interface
- `width`, default 8: operand width in bits. Legal range is ≥ 2. The product is 2·`width` bits.
- `clk_i`  in  1: single clock, rising-edge.
- `rst_n_i`  in  1: reset, asynchronous and active-low. Assertion immediately clears all state.
- `start_i`  in  1: request a multiply. Sampled only in IDLE.
- `a_i`  in  `width`: multiplicand. Captured on the accepting edge.
- `b_i`  in  `width`: multiplier. Captured on the accepting edge.
- `busy_o`  out  1: high while an operation is in progress (RUN or DONE).
- `done_o`  out  1: one-cycle pulse when `p_o` has been updated with a new product.
- `p_o`  out  2·`width`: last completed product. Held until the next completion.

## Operation
- Internal registers:
  - `mcand` (`width`): the multiplicand.
  - `prod` (2·`width`): accumulator in the high half, multiplier in the low half.
  - `cnt` ($clog2(`width`+1) bits).
  - `state`.
- One instance of `full_adder_nbits #(.width(width))`:
  - `a_i` = `prod[2w-1:w]`.
  - `b_i` = `prod[0]` ? `mcand` : 0.
  - `s_o` is `width`+1 bits; the carry is kept.
- FSM states: IDLE, RUN, DONE.
  - IDLE: when `start_i`=1, load `mcand`←`a_i`, `prod`←{`width`'b0, `b_i`}, `cnt`←0, and go to RUN. Otherwise stay in IDLE.
  - RUN: each edge, `prod`←{`s_o`, `prod[w-1:1]`} (the `width`+1 sum bits plus `width`-1 shifted bits = 2·`width`) and `cnt`←`cnt`+1.
    - When `cnt`=`width`-1, this edge is the last iteration: load `p_o` with the new `prod` value and go to DONE.
  - DONE: `done_o`=1 for exactly this cycle, then unconditionally go to IDLE.
- Outputs:
  - `busy_o` = (state≠IDLE).
  - `done_o` = (state==DONE). `done_o` is Moore, registered-state decoded.
- `start_i` is ignored in RUN and DONE. It is not queued. The requester must re-assert it once `busy_o` is low.
- Operands are captured, so `a_i`/`b_i` may change freely after the accepting edge without affecting the result.
- Arithmetic is unsigned and the result is exact. The maximum (2^w−1)² fits in 2·`width` bits, so there is no overflow. The adder carry is always captured into `prod[2w-1]` on the shift.
- Zero operands still take the full `width` iterations; there is no early termination.

## Timing
- Reset values, asserted asynchronously and held while `rst_n_i`=0:
  - state=IDLE.
  - `busy_o`=0, `done_o`=0, `p_o`=0.
  - `prod`=0, `mcand`=0, `cnt`=0.
- Latency: `start_i` is accepted at edge E0.
  - RUN iterations occur at edges E1..E`width`.
  - `done_o` is high in the cycle after E`width`.
  - `p_o` is valid from E`width` onward.
- `busy_o` rises after E0 and falls after edge E`width`+1.
- Throughput: if `start_i` is held high, a new operation is accepted at E`width`+2. Back-to-back period is `width`+2 cycles.
- Reset mid-RUN or in DONE: the operation is aborted, no `done_o` pulse is produced, and `p_o` returns to 0. After release, the first edge with `start_i`=1 is accepted normally.
- `start_i` coinciding with DONE is ignored. It is accepted only at the next edge, when the state is IDLE.
- The counter never wraps. It is reset at each accept and is only compared against `width`-1.

## Test plan
- Basic, `width`=8: a=13, b=11, pulse `start_i` → after 9 edges, `done_o`=1 for one cycle and `p_o`=143 (0x008F); `busy_o` high for exactly 9 cycles.
- Extremes, `width`=8:
  - a=255, b=255 → `p_o`=0xFE01, exercising carry capture.
  - a=0, b=200 → `p_o`=0, still after 9 edges.
  - a=1, b=255 → `p_o`=0x00FF.
- Start while busy: a=6, b=7 accepted; at edge 3 pulse `start_i` with a=2, b=2 → only one `done_o`, `p_o`=42, no second operation.
- Reset mid-operation: a=100, b=3; deassert `rst_n_i` during the 4th RUN cycle → `busy_o`, `done_o`, `p_o` clear immediately; after release, a=5, b=5 gives `p_o`=25.
- Back-to-back with `start_i` held high:
  - Two operations (9×9, then 3×4 applied after the first `done_o`) → `done_o` pulses 10 cycles apart.
  - `p_o`=81, then 12.
  - `p_o` holds 81 between the two pulses.
- Random, `width`=8 and `width`=4: 100 random operand pairs, each compared at `done_o` against `a*b` computed at 2·`width` bits → zero mismatches.
